// File: rtl/sargantana_ifill_responder.sv
// icache iFill responder: fetches a line as NBEATS memory beats and returns it in one resp cycle.
// Optional one-entry last-line buffer enabled by defining IFILL_LINE_BUF_EN.
module sargantana_ifill_responder #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   ifill_req_valid_i,
  input  logic [PADDR_WIDTH-1:0] ifill_req_paddr_i,
  output logic                   ifill_resp_valid_o,
  output logic [LINE_WIDTH-1:0]  ifill_resp_data_o,
  output logic                   ifill_resp_xcpt_o,
  output logic                   ifill_busy_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                   mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0]  mem_rdata_i,
  input  logic                   mem_rerr_i
);
  localparam int OFF    = $clog2(LINE_WIDTH/8);
  localparam int NBEATS = LINE_WIDTH/BEAT_WIDTH;
  localparam int CW     = $clog2(NBEATS);
  localparam int TW     = PADDR_WIDTH-OFF;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] RESP    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]                             state_q;
  logic [TW-1:0]                          tag_q;
  logic [CW-1:0]                          cnt_q;
  logic                                   kill_q, err_q;
  logic [NBEATS-1:0][BEAT_WIDTH-1:0]      line_q, line_nxt;
  logic [LINE_WIDTH-1:0]                  resp_data_q;
  logic                                   resp_xcpt_q;
  logic                                   last_beat, kill_nxt, err_nxt;
  logic                                   buf_hit;
  logic [LINE_WIDTH-1:0]                  buf_line;
  logic [TW-1:0]                          req_tag;

  assign req_tag = ifill_req_paddr_i[PADDR_WIDTH-1:OFF];

  // Line as it will look once the beat arriving this cycle is written.
  always_comb begin
    line_nxt        = line_q;
    line_nxt[cnt_q] = mem_rdata_i;
  end

  assign last_beat = mem_rvalid_i && (cnt_q == CW'(NBEATS-1));
  assign kill_nxt  = kill_q | ~ifill_req_valid_i;
  assign err_nxt   = err_q | (mem_rvalid_i & mem_rerr_i);

`ifdef IFILL_LINE_BUF_EN
  logic                  buf_valid_q, flush_seen_q, buf_wr;
  logic [TW-1:0]         buf_tag_q;
  logic [LINE_WIDTH-1:0] buf_data_q;
  logic [OFF-1:0]        unused_low;

  assign unused_low = ifill_req_paddr_i[OFF-1:0];
  assign buf_hit    = buf_valid_q && !flush_i && (buf_tag_q == req_tag);
  assign buf_line   = buf_data_q;
  // Killed fills still refresh the buffer; a flush seen anywhere in COLLECT vetoes the write.
  assign buf_wr     = (state_q == COLLECT) && last_beat && !err_nxt && !flush_seen_q && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q  <= 1'b0;
      flush_seen_q <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
    end else begin
      if (flush_i)     buf_valid_q <= 1'b0;
      else if (buf_wr) buf_valid_q <= 1'b1;
      if (buf_wr) begin
        buf_tag_q  <= tag_q;
        buf_data_q <= line_nxt;
      end
      if (state_q == IDLE)                    flush_seen_q <= 1'b0;
      else if (state_q == COLLECT && flush_i) flush_seen_q <= 1'b1;
    end
  end
`else
  logic [OFF:0] unused_in;

  assign unused_in = {flush_i, ifill_req_paddr_i[OFF-1:0]};
  assign buf_hit   = 1'b0;
  assign buf_line  = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      err_q       <= 1'b0;
      line_q      <= '0;
      resp_data_q <= '0;
      resp_xcpt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ifill_req_valid_i) begin
          if (buf_hit) begin
            resp_data_q <= buf_line;
            resp_xcpt_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            tag_q   <= req_tag;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        // Request is never retracted once raised; a kill only suppresses the response.
        REQ: begin
          kill_q <= kill_nxt;
          if (mem_req_ready_i) begin
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          kill_q <= kill_nxt;
          if (mem_rvalid_i) begin
            line_q <= line_nxt;
            cnt_q  <= cnt_q + CW'(1);
            err_q  <= err_nxt;
            if (last_beat) begin
              if (kill_nxt) begin
                state_q <= DONE;
              end else begin
                resp_data_q <= line_nxt;
                resp_xcpt_q <= err_nxt;
                state_q     <= RESP;
              end
            end
          end
        end
        RESP:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifill_resp_valid_o = (state_q == RESP);
  assign ifill_resp_data_o  = resp_data_q;
  assign ifill_resp_xcpt_o  = resp_xcpt_q;
  assign ifill_busy_o       = (state_q != IDLE);
  assign mem_req_valid_o    = (state_q == REQ);
  assign mem_req_addr_o     = {tag_q, {OFF{1'b0}}};

endmodule

// File: tb/tb_sargantana_ifill_responder.sv
// Randomized bench for sargantana_ifill_responder against a transaction-level model of the refill protocol.
module tb_sargantana_ifill_responder;
  localparam int PW = 40, LW = 256, BW = 64, NB = 4;

`ifdef IFILL_LINE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, ready, rvalid, rerr;
  logic [PW-1:0] paddr;
  logic [BW-1:0] rdata;
  logic          resp_valid, xcpt, busy, mem_req_valid;
  logic [LW-1:0] resp_data;
  logic [PW-1:0] mem_req_addr;

  sargantana_ifill_responder dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .ifill_req_valid_i  (req_valid),
    .ifill_req_paddr_i  (paddr),
    .ifill_resp_valid_o (resp_valid),
    .ifill_resp_data_o  (resp_data),
    .ifill_resp_xcpt_o  (xcpt),
    .ifill_busy_o       (busy),
    .mem_req_valid_o    (mem_req_valid),
    .mem_req_ready_i    (ready),
    .mem_req_addr_o     (mem_req_addr),
    .mem_rvalid_i       (rvalid),
    .mem_rdata_i        (rdata),
    .mem_rerr_i         (rerr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // model: last-line buffer contents and last line presented on a resp pulse
  bit          m_valid = 1'b0;
  logic [34:0] m_tag   = '0;
  logic [LW-1:0] m_line = '0, last_data = '0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One refill transaction; inputs driven and outputs sampled at negedge.
  task automatic fill(input logic [PW-1:0] pa, input int rdy_wait, input int kill_beat,
                      input logic [3:0] errm, input bit flush_mid, input bit flush_req, input bit gaps);
    logic [LW-1:0] line;
    bit hit, killed;
    for (int k = 0; k < NB; k++) line[k*BW +: BW] = {$urandom, $urandom};
    hit = BUF_EN && m_valid && (m_tag == pa[PW-1:5]) && !flush_req;
    if (BUF_EN && flush_req) m_valid = 1'b0;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_resp", resp_valid, 0);
    chk("idle_memreq", mem_req_valid, 0);
    req_valid = 1'b1; paddr = pa; flush = flush_req;
    rvalid = 1'($urandom_range(0, 1)); rdata = {$urandom, $urandom};

    if (hit) begin
      @(negedge clk);
      flush = 1'b0; rvalid = 1'b0;
      chk("hit_resp_valid", resp_valid, 1);
      chk("hit_data", resp_data, m_line);
      chk("hit_xcpt", xcpt, 0);
      chk("hit_no_memreq", mem_req_valid, 0);
      last_data = m_line;
      req_valid = 1'b0;
      @(negedge clk);
      chk("done_busy", busy, 1);
      chk("done_resp", resp_valid, 0);
      chk("done_memreq", mem_req_valid, 0);
      return;
    end

    for (int n = 0; n <= rdy_wait; n++) begin
      @(negedge clk);
      flush = 1'b0; rvalid = 1'b0;
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, {pa[PW-1:5], 5'b0});
      chk("req_no_resp", resp_valid, 0);
      ready = (n == rdy_wait);
    end

    killed = 1'b0;
    for (int k = 0; k < NB; k++) begin
      int gap;
      gap = (gaps && $urandom_range(0, 2) == 0) ? 1 : 0;
      repeat (gap) begin
        @(negedge clk);
        ready = 1'b0; rvalid = 1'b0; flush = 1'b0;
        chk("gap_no_resp", resp_valid, 0);
      end
      @(negedge clk);
      ready = 1'b0; flush = 1'b0;
      chk("collect_no_req", mem_req_valid, 0);
      chk("collect_busy", busy, 1);
      chk("collect_no_resp", resp_valid, 0);
      rvalid = 1'b1; rdata = line[k*BW +: BW]; rerr = errm[k];
      if (k == kill_beat) begin req_valid = 1'b0; killed = 1'b1; end
      if (flush_mid && k == 1) flush = 1'b1;
    end

    @(negedge clk);
    rvalid = 1'b0; rerr = 1'b0; flush = 1'b0;
    if (!killed) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_data", resp_data, line);
      chk("resp_xcpt", xcpt, |errm);
      last_data = line;
      req_valid = 1'b0;
      @(negedge clk);
    end
    chk("done_busy", busy, 1);
    chk("done_resp", resp_valid, 0);
    chk("hold_data", resp_data, last_data);
    rvalid = 1'($urandom_range(0, 1)); rdata = {$urandom, $urandom};

    if (BUF_EN) begin
      if (flush_mid) m_valid = 1'b0;
      else if (errm == 4'b0) begin
        m_valid = 1'b1; m_tag = pa[PW-1:5]; m_line = line;
      end
    end
  endtask

  task automatic reset_mid(input logic [PW-1:0] pa);
    @(negedge clk); rvalid = 1'b0; req_valid = 1'b1; paddr = pa;
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0; rvalid = 1'b1; rdata = 64'h0b0;
    @(negedge clk); rdata = 64'h0b1;
    @(negedge clk); rdata = 64'h0b2; rst = 1'b1;
    @(negedge clk); rst = 1'b0; rdata = 64'h0b3; req_valid = 1'b0;
    chk("rst_resp", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_memreq", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_xcpt", xcpt, 0);
    @(negedge clk); rvalid = 1'b0;
    chk("rst_stray_busy", busy, 0);
    chk("rst_stray_resp", resp_valid, 0);
    m_valid = 1'b0; last_data = '0;
  endtask

  initial begin
    logic [PW-1:0] bases [4];
    bases[0] = 40'h80000020; bases[1] = 40'h80000040;
    bases[2] = 40'h12345600; bases[3] = 40'hff_fffe_0e0;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; paddr = '0;
    ready = 1'b0; rvalid = 1'b1; rdata = 64'hdead; rerr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_resp", resp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_memreq", mem_req_valid, 0);
    chk("reset_data", resp_data, 0);
    rst = 1'b0;

    fill(40'h80000020, 0, -1, 4'b0000, 0, 0, 0);  // miss, no stalls
    fill(40'h80000020, 0, -1, 4'b0000, 0, 0, 0);  // repeat: hit when buffered
    fill(40'h80000040, 3, -1, 4'b0000, 0, 0, 0);  // ready backpressure
    fill(40'h80001000, 0,  2, 4'b0000, 0, 0, 0);  // kill after beat 1
    fill(40'h80001000, 0, -1, 4'b0000, 0, 0, 0);
    fill(40'h80002000, 0, -1, 4'b0100, 0, 0, 0);  // error on beat 2
    fill(40'h80002000, 0, -1, 4'b0000, 0, 0, 0);
    fill(40'h80002000, 0, -1, 4'b0000, 0, 1, 0);  // flush in compare cycle
    fill(40'h80003000, 0, -1, 4'b0000, 1, 0, 0);  // flush during collect
    fill(40'h80003000, 0, -1, 4'b0000, 0, 0, 0);
    reset_mid(40'h80004000);
    fill(40'h80004000, 0, -1, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [PW-1:0] pa;
      int kb;
      logic [3:0] em;
      pa = bases[$urandom_range(0, 3)] | PW'($urandom_range(0, 31));
      kb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      em = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      fill(pa, $urandom_range(0, 3), kb, em, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, 1'b1);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
